niosii_system_sysid_ext: RTL and testbench

- Parametrised next-generation system-ID slave on the Nios II Avalon-MM fabric.
- Returns the build ID and build timestamp as before, and adds:
  - a free-running uptime counter read atomically through low/high snapshot words;
  - two scratch registers with a write-once lock;
  - a read-transaction counter;
  - pipelined reads with fixed latency, signalled by readdatavalid.
- Software uses it for build identification, elapsed-time measurement and bus sanity checks.

---
 rtl/niosii_system_sysid_ext.sv | 199 +++++++++++++++++++
 tb/tb_niosii_system_sysid_ext.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_system_sysid_ext.sv
// System-ID slave for the Nios II Avalon-MM fabric: build ID/timestamp, uptime counter with
// atomic LO/HI snapshot, lockable scratch registers and a read counter, with fixed-latency reads.
module niosii_system_sysid_ext #(
    parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'd1393714090,
    parameter int          READ_LATENCY = 2,
    parameter int          UPTIME_W     = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH0  = 3'd4;
    localparam logic [2:0] ADDR_SCRATCH1  = 3'd5;
    localparam logic [2:0] ADDR_CONTROL   = 3'd6;
    localparam logic [2:0] ADDR_RDCOUNT   = 3'd7;

    // Request decode
    logic rd_accept;
    logic ctrl_wr;
    logic uptime_clr;
    logic rdcnt_clr;
    logic freeze_wr;
    logic lock_set;

    always_comb begin
        rd_accept  = read & ~write;
        ctrl_wr    = write && (address == ADDR_CONTROL);
        uptime_clr = ctrl_wr & byteenable[0] & writedata[0];
        freeze_wr  = ctrl_wr & byteenable[0];
        rdcnt_clr  = ctrl_wr & byteenable[0] & writedata[2];
        lock_set   = ctrl_wr & byteenable[1] & writedata[8];
    end

    // Uptime counter and high-word snapshot
    logic [UPTIME_W-1:0] uptime_reg;
    logic [UPTIME_W-1:0] uptime_next;
    logic [31:0]         hi_snap_reg;
    logic [31:0]         hi_snap_next;
    logic [31:0]         uptime_hi_ext;
    logic                freeze_reg;
    logic                freeze_next;
    logic                lock_reg;
    logic                lock_next;

    always_comb begin
        uptime_hi_ext = '0;
        uptime_hi_ext[UPTIME_W-33:0] = uptime_reg[UPTIME_W-1:32];
    end

    always_comb begin
        uptime_next = uptime_reg;
        if (uptime_clr) begin
            uptime_next = '0;
        end else if (!freeze_reg) begin
            uptime_next = uptime_reg + UPTIME_W'(1);
        end
    end

    // The snapshot only moves on a LO read, so a following HI read pairs with it.
    always_comb begin
        hi_snap_next = hi_snap_reg;
        if (rd_accept && (address == ADDR_UPTIME_LO)) begin
            hi_snap_next = uptime_hi_ext;
        end
    end

    always_comb begin
        freeze_next = freeze_wr ? writedata[1] : freeze_reg;
        lock_next   = lock_reg | lock_set;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            uptime_reg  <= '0;
            hi_snap_reg <= '0;
            freeze_reg  <= 1'b0;
            lock_reg    <= 1'b0;
        end else begin
            uptime_reg  <= uptime_next;
            hi_snap_reg <= hi_snap_next;
            freeze_reg  <= freeze_next;
            lock_reg    <= lock_next;
        end
    end

    // Scratch registers, byte-writable until locked
    logic [31:0] scratch_q [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_scratch
            localparam logic [2:0] SCR_ADDR = ADDR_SCRATCH0 + 3'(gi);
            logic [31:0] scratch_reg;
            logic [31:0] scratch_next;

            always_comb begin
                scratch_next = scratch_reg;
                if (write && (address == SCR_ADDR) && !lock_reg) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteenable[b]) begin
                            scratch_next[8*b +: 8] = writedata[8*b +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    scratch_reg <= '0;
                end else begin
                    scratch_reg <= scratch_next;
                end
            end

            assign scratch_q[gi] = scratch_reg;
        end
    endgenerate

    // Read-transaction counter; a clear overrides a same-cycle increment
    logic [31:0] read_count_reg;
    logic [31:0] read_count_next;

    always_comb begin
        read_count_next = read_count_reg;
        if (rdcnt_clr) begin
            read_count_next = '0;
        end else if (rd_accept && (read_count_reg != 32'hFFFF_FFFF)) begin
            read_count_next = read_count_reg + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_count_reg <= '0;
        end else begin
            read_count_reg <= read_count_next;
        end
    end

    // Read data is taken from current register state, ahead of this cycle's updates
    logic [31:0] control_rd;
    logic [31:0] rd_data_sel;

    always_comb begin
        control_rd    = '0;
        control_rd[1] = freeze_reg;
        control_rd[8] = lock_reg;
    end

    always_comb begin
        rd_data_sel = '0;
        case (address)
            ADDR_ID:        rd_data_sel = ID_VALUE;
            ADDR_TIMESTAMP: rd_data_sel = TIMESTAMP;
            ADDR_UPTIME_LO: rd_data_sel = uptime_reg[31:0];
            ADDR_UPTIME_HI: rd_data_sel = hi_snap_reg;
            ADDR_SCRATCH0:  rd_data_sel = scratch_q[0];
            ADDR_SCRATCH1:  rd_data_sel = scratch_q[1];
            ADDR_CONTROL:   rd_data_sel = control_rd;
            ADDR_RDCOUNT:   rd_data_sel = read_count_reg;
            default:        rd_data_sel = '0;
        endcase
    end

    // Fixed-latency pipeline; data is zeroed whenever its valid bit is low
    logic        valid_pipe_reg [READ_LATENCY];
    logic [31:0] data_pipe_reg  [READ_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                valid_pipe_reg[i] <= 1'b0;
                data_pipe_reg[i]  <= '0;
            end
        end else begin
            valid_pipe_reg[0] <= rd_accept;
            data_pipe_reg[0]  <= rd_accept ? rd_data_sel : 32'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
                data_pipe_reg[i]  <= data_pipe_reg[i-1];
            end
        end
    end

    assign readdata      = data_pipe_reg[READ_LATENCY-1];
    assign readdatavalid = valid_pipe_reg[READ_LATENCY-1];

endmodule

// File: tb/tb_niosii_system_sysid_ext.sv
// Self-checking bench for niosii_system_sysid_ext: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the register map.
module tb_niosii_system_sysid_ext;

    localparam logic [31:0] ID_VALUE  = 32'h0000_0000;
    localparam logic [31:0] TIMESTAMP = 32'd1393714090;
    localparam int          LAT       = 2;
    localparam int          UPTIME_W  = 64;
    localparam logic [63:0] UP_MASK   = (UPTIME_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                         : ((64'd1 << UPTIME_W) - 64'd1);

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    niosii_system_sysid_ext #(
        .ID_VALUE     (ID_VALUE),
        .TIMESTAMP    (TIMESTAMP),
        .READ_LATENCY (LAT),
        .UPTIME_W     (UPTIME_W)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_log[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // Reference model state
    logic [63:0] m_up;
    logic [31:0] m_hi;
    logic [31:0] m_s [2];
    logic        m_frz;
    logic        m_lock;
    logic [31:0] m_rc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return ID_VALUE;
            3'd1:    return TIMESTAMP;
            3'd2:    return m_up[31:0];
            3'd3:    return m_hi;
            3'd4:    return m_s[0];
            3'd5:    return m_s[1];
            3'd6:    return (32'(m_lock) << 8) | (32'(m_frz) << 1);
            default: return m_rc;
        endcase
    endfunction

    task automatic check_outputs();
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("rdvalid", 32'(readdatavalid), 32'd1);
            check("rdata", readdata, e.data);
        end else begin
            check("rdvalid_idle", 32'(readdatavalid), 32'd0);
            check("rdata_idle", readdata, 32'd0);
        end
        if (readdatavalid === 1'b1) rd_log.push_back(readdata);
    endtask

    task automatic step(input logic rst, input logic rd, input logic wr, input logic [2:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        logic        rd_acc;
        logic        ctl;
        logic [63:0] up_n;
        logic [31:0] hi_n;
        logic [31:0] rc_n;
        reset      = rst;
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = wd;
        byteenable = be;
        @(posedge clk);
        cyc++;
        if (rd || wr || rst)
            $display("cyc %0d rst=%0b rd=%0b wr=%0b addr=%0d wdata=%h be=%b",
                     cyc, rst, rd, wr, a, wd, be);
        if (rst) begin
            m_up = 0; m_hi = 0; m_s[0] = 0; m_s[1] = 0;
            m_frz = 0; m_lock = 0; m_rc = 0;
            exp_q.delete();
        end else begin
            rd_acc = rd && !wr;
            ctl    = wr && (a == 3'd6);
            hi_n   = m_hi;
            if (rd_acc) begin
                exp_q.push_back('{cyc + LAT - 1, model_read(a)});
                if (a == 3'd2) hi_n = 32'(m_up >> 32);
            end
            rc_n = m_rc;
            if (ctl && be[0] && wd[2]) rc_n = 0;
            else if (rd_acc && m_rc != 32'hFFFF_FFFF) rc_n = m_rc + 1;
            if (ctl && be[0] && wd[0]) up_n = 0;
            else if (m_frz) up_n = m_up;
            else up_n = (m_up + 64'd1) & UP_MASK;
            if (wr && (a == 3'd4 || a == 3'd5) && !m_lock) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_s[a - 3'd4][8*b +: 8] = wd[8*b +: 8];
            end
            if (ctl && be[0]) m_frz = wd[1];
            if (ctl && be[1] && wd[8]) m_lock = 1'b1;
            m_up = up_n;
            m_hi = hi_n;
            m_rc = rc_n;
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    endtask

    task automatic rd_word(input logic [2:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'd0, 4'd0);
    endtask

    task automatic wr_word(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
        step(1'b0, 1'b0, 1'b1, a, wd, be);
    endtask

    int          clr_cyc;
    logic [31:0] frz_a;

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = 3'd0; writedata = 32'd0; byteenable = 4'd0;

        // Reset state and ID/timestamp reads
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        idle(7);
        rd_log.delete();
        rd_word(3'd0);
        rd_word(3'd1);
        idle(LAT + 2);
        check("id_ts_count", rd_log.size(), 32'd2);
        check("id_value", rd_log[0], ID_VALUE);
        check("timestamp", rd_log[1], TIMESTAMP);

        // Read counter: back-to-back from reset, then a read masked by a write
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        rd_log.delete();
        for (int i = 0; i < 4; i++) rd_word(3'd7);
        idle(LAT + 1);
        check("rc_count", rd_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) check("rc_seq", rd_log[i], 32'(i));
        rd_log.delete();
        step(1'b0, 1'b1, 1'b1, 3'd7, 32'h1234_5678, 4'hF);
        idle(LAT + 1);
        check("rw_no_pulse", rd_log.size(), 32'd0);
        rd_word(3'd7);
        idle(LAT + 1);
        check("rc_unchanged", rd_log[0], 32'd4);

        // Uptime LO/HI atomicity across a 32-bit rollover
        force dut.uptime_reg = 64'h0000_0001_FFFF_FFFF;
        @(posedge clk);
        cyc++;
        #1;
        release dut.uptime_reg;
        m_up = 64'h0000_0001_FFFF_FFFF;
        check_outputs();
        @(negedge clk);
        rd_log.delete();
        rd_word(3'd2);
        idle(3);
        rd_word(3'd3);
        idle(LAT + 1);
        check("uptime_lo", rd_log[0], 32'hFFFF_FFFF);
        check("uptime_hi", rd_log[1], 32'd1);

        // Freeze holds the counter; clear restarts it from zero
        wr_word(3'd6, 32'd2, 4'b0001);
        rd_log.delete();
        rd_word(3'd2);
        idle(4);
        rd_word(3'd2);
        idle(LAT + 1);
        frz_a = rd_log[0];
        check("freeze_hold", rd_log[1], frz_a);
        wr_word(3'd6, 32'd1, 4'b0001);
        clr_cyc = cyc;
        idle(5);
        rd_log.delete();
        rd_word(3'd2);
        check("uptime_after_clr_small", 32'(m_up < 64'(cyc - clr_cyc + 1)), 32'd1);
        idle(LAT + 1);
        check("uptime_below_elapsed", 32'(rd_log[0] < 32'(cyc - clr_cyc)), 32'd1);

        // Scratch byte enables and write-once lock
        wr_word(3'd4, 32'hA5A5_A5A5, 4'b0011);
        rd_log.delete();
        rd_word(3'd4);
        idle(LAT + 1);
        check("scratch_be", rd_log[0], 32'h0000_A5A5);
        wr_word(3'd6, 32'h0000_0100, 4'b1111);
        wr_word(3'd4, 32'hFFFF_FFFF, 4'b1111);
        wr_word(3'd6, 32'h0000_0000, 4'b0010);
        rd_log.delete();
        rd_word(3'd4);
        rd_word(3'd6);
        idle(LAT + 1);
        check("scratch_locked", rd_log[0], 32'h0000_A5A5);
        check("control_lock", rd_log[1], 32'h0000_0100);

        // Reads in flight are discarded by reset
        rd_word(3'd0);
        rd_word(3'd1);
        rd_word(3'd7);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        rd_log.delete();
        idle(LAT + 2);
        check("flush_no_pulse", rd_log.size(), 32'd0);
        rd_word(3'd7);
        idle(LAT + 1);
        check("rc_after_reset", rd_log[0], 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                 3'($urandom), $urandom, 4'($urandom));
        end
        idle(LAT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
